seven_segment_scanner: RTL and testbench

Downstream display stage for the two-digit seven-segment decoder. It takes the decoder's tens and ones segment patterns and time-multiplexes them onto one shared 7-bit segment bus, with a one-hot digit enable per physical digit. Dead-time blanking between digits prevents ghosting. The block latches both patterns once per frame so the tens/ones pair shown is always coherent. It sits between the decoder and the board pins; any polarity inversion is done outside the block.

---
 rtl/seven_segment_scanner_if.sv | 30 +++
 rtl/seven_segment_scanner.sv | 165 ++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Segment-scanner bus: decoder-side inputs and board-side outputs of the
// two-digit multiplexed seven-segment display stage.
interface seven_segment_scanner_if;
    logic       enable;
    logic [6:0] tens_digit;
    logic [6:0] ones_digit;
    logic [6:0] seg_out;
    logic [1:0] digit_en;
    logic       frame_done;

    // Driver side: requests scanning and supplies the two segment patterns.
    modport master (
        output enable,
        output tens_digit,
        output ones_digit,
        input  seg_out,
        input  digit_en,
        input  frame_done
    );

    // Scanner side: consumes the patterns and drives the shared display pins.
    modport slave (
        input  enable,
        input  tens_digit,
        input  ones_digit,
        output seg_out,
        output digit_en,
        output frame_done
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexes a tens and a ones segment pattern
// onto one shared 7-bit bus with a one-hot digit enable. Both patterns are
// latched together at each frame start so a displayed pair is always coherent,
// and optional dark slots between digits keep one digit from ghosting onto the
// other. Every output comes straight from a flop.
module seven_segment_scanner #(
    parameter int unsigned DIGIT_CYCLES = 4,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_segment_scanner_if.slave bus
);

    // Counter must hold DIGIT_CYCLES-1 and BLANK_CYCLES-1; never narrower than 1 bit.
    localparam int unsigned SPAN_DB = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned SPAN    = (SPAN_DB > 2) ? SPAN_DB : 2;
    localparam int          CNT_W   = $clog2(SPAN);
    localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);

    localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = HAS_BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TENS_ON = 3'd1;
    localparam logic [2:0] ST_BLANK_A = 3'd2;
    localparam logic [2:0] ST_ONES_ON = 3'd3;
    localparam logic [2:0] ST_BLANK_B = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [6:0]       tens_lat;
    logic [6:0]       tens_nxt;
    logic [6:0]       ones_lat;
    logic [6:0]       ones_nxt;
    logic             frame_end;
    logic             final_nxt;

    logic [6:0]       seg_p0;
    logic [1:0]       digit_en_p0;
    logic             frame_done_p0;

    // Next-state, slot counter and frame-start latching decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tens_nxt  = tens_lat;
        ones_nxt  = ones_lat;
        frame_end = 1'b0;

        case (state)
            ST_IDLE: begin
            end
            ST_TENS_ON: begin
                if (cnt == '0) begin
                    if (HAS_BLANK) begin
                        state_nxt = ST_BLANK_A;
                        cnt_nxt   = BLANK_LOAD;
                    end else begin
                        state_nxt = ST_ONES_ON;
                        cnt_nxt   = DIGIT_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_BLANK_A: begin
                if (cnt == '0) begin
                    state_nxt = ST_ONES_ON;
                    cnt_nxt   = DIGIT_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_ONES_ON: begin
                if (cnt == '0) begin
                    if (HAS_BLANK) begin
                        state_nxt = ST_BLANK_B;
                        cnt_nxt   = BLANK_LOAD;
                    end else begin
                        frame_end = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_BLANK_B: begin
                if (cnt == '0) begin
                    frame_end = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // enable only matters while idle or on the edge that closes a frame;
        // a drop or glitch anywhere else is ignored and the frame completes.
        if ((state == ST_IDLE) || frame_end) begin
            if (bus.enable) begin
                state_nxt = ST_TENS_ON;
                cnt_nxt   = DIGIT_LOAD;
                tens_nxt  = bus.tens_digit;
                ones_nxt  = bus.ones_digit;
            end else begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        end
    end

    // Output decode of the upcoming state so the registered outputs line up with it.
    always_comb begin
        seg_p0      = '0;
        digit_en_p0 = 2'b00;
        case (state_nxt)
            ST_TENS_ON: begin
                seg_p0      = tens_nxt;
                digit_en_p0 = 2'b10;
            end
            ST_ONES_ON: begin
                seg_p0      = ones_nxt;
                digit_en_p0 = 2'b01;
            end
            default: begin
            end
        endcase
        final_nxt     = HAS_BLANK ? (state_nxt == ST_BLANK_B) : (state_nxt == ST_ONES_ON);
        frame_done_p0 = final_nxt && (cnt_nxt == '0);
    end

    // Control state: FSM, slot counter and the coherent pattern latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tens_lat <= '0;
            ones_lat <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tens_lat <= tens_nxt;
            ones_lat <= ones_nxt;
        end
    end

    // p0 -> output registers: pins change only on clock edges or async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg_out    <= '0;
            bus.digit_en   <= 2'b00;
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg_out    <= seg_p0;
            bus.digit_en   <= digit_en_p0;
            bus.frame_done <= frame_done_p0;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed scenarios plus randomized traffic
// checked against a frame-position model of the display timing.
module tb_seven_segment_scanner;

    localparam int DA = 4;
    localparam int BA = 1;
    localparam int FA = 2 * DA + 2 * BA;
    localparam int DB = 2;
    localparam int BB = 0;
    localparam int FB = 2 * DB + 2 * BB;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    seven_segment_scanner_if ifa ();
    seven_segment_scanner_if ifb ();

    seven_segment_scanner #(.DIGIT_CYCLES(DA), .BLANK_CYCLES(BA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    seven_segment_scanner #(.DIGIT_CYCLES(DB), .BLANK_CYCLES(BB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {digit_en, seg_out, frame_done} at a given cycle of a frame.
    function automatic logic [9:0] frame_out(input int pos, input int d, input int b,
                                             input logic [6:0] t, input logic [6:0] o);
        logic [1:0] en;
        logic [6:0] seg;
        logic       done;
        en  = 2'b00;
        seg = 7'h00;
        if (pos < d) begin
            en  = 2'b10;
            seg = t;
        end else if (pos >= d + b && pos < 2 * d + b) begin
            en  = 2'b01;
            seg = o;
        end
        done = (pos == 2 * d + 2 * b - 1);
        return {en, seg, done};
    endfunction

    // Reference model: idle flag, position within the frame, latched pair.
    logic       ma_idle, mb_idle;
    int         ma_pos, mb_pos;
    logic [6:0] ma_t, ma_o, mb_t, mb_o;
    logic [9:0] exp_a, exp_b, act_a, act_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_idle <= 1'b1; ma_pos <= 0; ma_t <= '0; ma_o <= '0;
        end else if (ma_idle || ma_pos == FA - 1) begin
            ma_pos <= 0;
            if (ifa.enable) begin
                ma_idle <= 1'b0; ma_t <= ifa.tens_digit; ma_o <= ifa.ones_digit;
            end else begin
                ma_idle <= 1'b1;
            end
        end else begin
            ma_pos <= ma_pos + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_idle <= 1'b1; mb_pos <= 0; mb_t <= '0; mb_o <= '0;
        end else if (mb_idle || mb_pos == FB - 1) begin
            mb_pos <= 0;
            if (ifb.enable) begin
                mb_idle <= 1'b0; mb_t <= ifb.tens_digit; mb_o <= ifb.ones_digit;
            end else begin
                mb_idle <= 1'b1;
            end
        end else begin
            mb_pos <= mb_pos + 1;
        end
    end

    always_comb begin
        exp_a = ma_idle ? 10'd0 : frame_out(ma_pos, DA, BA, ma_t, ma_o);
        exp_b = mb_idle ? 10'd0 : frame_out(mb_pos, DB, BB, mb_t, mb_o);
        act_a = {ifa.digit_en, ifa.seg_out, ifa.frame_done};
        act_b = {ifb.digit_en, ifb.seg_out, ifb.frame_done};
    end

    task automatic do_reset();
        rst_n = 1'b0;
        ifa.enable = 1'b0;
        ifb.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ifa.enable = 1'b1; ifa.tens_digit = 7'h7F; ifa.ones_digit = 7'h7F;
        ifb.enable = 1'b1; ifb.tens_digit = 7'h7F; ifb.ones_digit = 7'h7F;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (act_a !== 10'd0) begin
                errors++;
                $display("FAIL reset_a cyc=%0d actual=%h required=%h", k, act_a, 10'd0);
            end
            checks++;
            if (act_b !== 10'd0) begin
                errors++;
                $display("FAIL reset_b cyc=%0d actual=%h required=%h", k, act_b, 10'd0);
            end
        end
        ifa.enable = 1'b0;
        ifb.enable = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (act_a !== 10'd0) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d actual=%h required=%h", k, act_a, 10'd0);
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [9:0] exp;
        int p;
        do_reset();
        ifa.tens_digit = 7'h06; ifa.ones_digit = 7'h5B; ifa.enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            p = k % 10;
            if (p < 4)       exp = {2'b10, 7'h06, 1'b0};
            else if (p == 4) exp = {2'b00, 7'h00, 1'b0};
            else if (p < 9)  exp = {2'b01, 7'h5B, 1'b0};
            else             exp = {2'b00, 7'h00, 1'b1};
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL basic_frame cyc=%0d actual=%h required=%h", k, act_a, exp);
            end
        end
        ifa.enable = 1'b0;
    endtask

    task automatic test_coherency();
        logic [9:0] exp;
        do_reset();
        ifa.tens_digit = 7'h06; ifa.ones_digit = 7'h5B; ifa.enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp = (k < 10) ? frame_out(k, DA, BA, 7'h06, 7'h5B)
                           : frame_out(k - 10, DA, BA, 7'h3F, 7'h4F);
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL coherency cyc=%0d actual=%h required=%h", k, act_a, exp);
            end
            if (k == 6) begin
                ifa.tens_digit = 7'h3F; ifa.ones_digit = 7'h4F;
            end
        end
        ifa.enable = 1'b0;
    endtask

    task automatic test_graceful_stop();
        logic [9:0] exp;
        do_reset();
        ifa.tens_digit = 7'h06; ifa.ones_digit = 7'h5B; ifa.enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k < 10)       exp = frame_out(k, DA, BA, 7'h06, 7'h5B);
            else if (k < 16)  exp = 10'd0;
            else              exp = frame_out(k - 16, DA, BA, 7'h06, 7'h5B);
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL graceful_stop cyc=%0d actual=%h required=%h", k, act_a, exp);
            end
            if (k == 2)  ifa.enable = 1'b0;
            if (k == 15) ifa.enable = 1'b1;
        end
        ifa.enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        logic [6:0] t, o;
        do_reset();
        t = 7'($urandom); o = 7'($urandom);
        ifa.tens_digit = t; ifa.ones_digit = o; ifa.enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            exp = frame_out(k % FA, DA, BA, t, o);
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d actual=%h required=%h", k, act_a, exp);
            end
            ifa.enable = (k != 13);
        end
        ifa.enable = 1'b0;
    endtask

    task automatic test_no_blank();
        logic [9:0] exp;
        logic [6:0] t, o;
        do_reset();
        t = 7'($urandom) | 7'h01; o = 7'($urandom) | 7'h40;
        ifb.tens_digit = t; ifb.ones_digit = o; ifb.enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp = ((k % 4) < 2) ? {2'b10, t, 1'b0} : {2'b01, o, (k % 4) == 3};
            checks++;
            if (act_b !== exp) begin
                errors++;
                $display("FAIL no_blank cyc=%0d actual=%h required=%h", k, act_b, exp);
            end
        end
        ifb.enable = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [9:0] exp;
        do_reset();
        ifa.tens_digit = 7'h06; ifa.ones_digit = 7'h5B; ifa.enable = 1'b1;
        for (int k = 0; k < 7; k++) @(negedge clk);
        checks++;
        if (act_a !== {2'b01, 7'h5B, 1'b0}) begin
            errors++;
            $display("FAIL pre_async_ones actual=%h required=%h", act_a, {2'b01, 7'h5B, 1'b0});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act_a !== 10'd0) begin
            errors++;
            $display("FAIL async_reset actual=%h required=%h", act_a, 10'd0);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp = frame_out(k, DA, BA, 7'h06, 7'h5B);
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL after_async cyc=%0d actual=%h required=%h", k, act_a, exp);
            end
        end
        ifa.enable = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL random_a cyc=%0d actual=%h required=%h", k, act_a, exp_a);
            end
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL random_b cyc=%0d actual=%h required=%h", k, act_b, exp_b);
            end
            checks++;
            if (ifa.digit_en === 2'b11 || ifb.digit_en === 2'b11) begin
                errors++;
                $display("FAIL both_digits cyc=%0d actual=%b/%b required=not 11", k, ifa.digit_en, ifb.digit_en);
            end
            ifa.enable = ($urandom_range(0, 3) != 0);
            ifb.enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                ifa.tens_digit = 7'($urandom); ifa.ones_digit = 7'($urandom);
                ifb.tens_digit = 7'($urandom); ifb.ones_digit = 7'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        ifa.enable = 1'b0;
        ifb.enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        ifa.enable = 1'b0; ifa.tens_digit = '0; ifa.ones_digit = '0;
        ifb.enable = 1'b0; ifb.tens_digit = '0; ifb.ones_digit = '0;
        #1;
        test_reset();
        test_basic_frame();
        test_coherency();
        test_graceful_stop();
        test_back_to_back();
        test_no_blank();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
